// File: rtl/pwt_pkg.sv
// Shared types and helpers for the perceptron weight table: FSM states,
// index-width derivation, weight/vector types and the saturating step.
package pwt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPD_RD = 2'd1,
      UPD_WR = 2'd2
   } pwt_state_e;

   localparam int PWT_WEIGHT_W = 8;
   localparam int PWT_HIST_LEN = 8;

   typedef logic signed [PWT_WEIGHT_W-1:0] pwt_weight_t;
   typedef pwt_weight_t [PWT_HIST_LEN:0]   pwt_vec_t;

   function automatic int pwt_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One +/-1 step clamped to the signed range of a width-bit weight.
   function automatic logic signed [31:0] pwt_sat_step(input logic signed [31:0] w,
                                                       input logic             up,
                                                       input int               width);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (width - 1));
      if (up) begin
         return (w >= hi) ? hi : w + 32'sd1;
      end else begin
         return (w <= lo) ? lo : w - 32'sd1;
      end
   endfunction

endpackage

// File: rtl/pwt_train_unit.sv
// Combinational perceptron training step: every lane of a weight vector moves
// one step toward agreement with the resolved outcome, saturating at the rails.
module pwt_train_unit
   import pwt_pkg::*;
#(
   parameter int HIST_LEN = 8,
   parameter int WEIGHT_W = 8
) (
   input  logic [(HIST_LEN+1)*WEIGHT_W-1:0] i_old_vec,
   input  logic [HIST_LEN-1:0]              i_hist,
   input  logic                             i_taken,
   output logic [(HIST_LEN+1)*WEIGHT_W-1:0] o_new_vec
);

   for (genvar j = 0; j <= HIST_LEN; j++) begin : g_lane
      if (j == 0) begin : g_bias
         assign o_new_vec[0 +: WEIGHT_W] =
            WEIGHT_W'(pwt_sat_step(32'(signed'(i_old_vec[0 +: WEIGHT_W])), i_taken, WEIGHT_W));
      end else begin : g_hist
         // History bit j-1 agreeing with the outcome strengthens weight j.
         assign o_new_vec[j*WEIGHT_W +: WEIGHT_W] =
            WEIGHT_W'(pwt_sat_step(32'(signed'(i_old_vec[j*WEIGHT_W +: WEIGHT_W])),
                                   ~(i_hist[j-1] ^ i_taken), WEIGHT_W));
      end
   end

endmodule

// File: rtl/perceptron_weight_table.sv
// Perceptron weight store: NUM_WAYS one-cycle lookups plus a read-modify-write trainer.
// Optional macro PWT_WRITE_BYPASS_EN forwards the entry being written to same-cycle lookups.
module perceptron_weight_table
   import pwt_pkg::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int HIST_LEN = 8,
   parameter int WEIGHT_W = 8,
   parameter int DEPTH    = 256,
   parameter int SUM_W    = 16,
   parameter int THRESH   = 29,
   parameter int IDX_W    = pwt_idx_w(DEPTH)
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      pred_valid,
   output logic                                      pred_ready,
   input  logic [NUM_WAYS*IDX_W-1:0]                 pred_idx,
   output logic                                      resp_valid,
   output logic [NUM_WAYS*(HIST_LEN+1)*WEIGHT_W-1:0] resp_weights,
   input  logic                                      upd_valid,
   output logic                                      upd_ready,
   input  logic [IDX_W-1:0]                          upd_idx,
   input  logic [HIST_LEN-1:0]                       upd_hist,
   input  logic                                      upd_taken,
   input  logic                                      upd_mispred,
   input  logic [SUM_W-1:0]                          upd_sum,
   output logic                                      train_done
);

   localparam int VEC_W = (HIST_LEN + 1) * WEIGHT_W;

   logic [VEC_W-1:0]          r_mem [DEPTH];
   pwt_state_e                r_state;
   pwt_state_e                w_state_nxt;
   logic [IDX_W-1:0]          r_idx;
   logic [HIST_LEN-1:0]       r_hist;
   logic                      r_taken;
   logic [VEC_W-1:0]          r_new_vec;
   logic [VEC_W-1:0]          w_train_vec;
   logic                      r_resp_valid;
   logic                      r_train_done;
   logic [NUM_WAYS*VEC_W-1:0] r_resp_weights;
   logic [NUM_WAYS*VEC_W-1:0] w_lookup;
   logic [SUM_W:0]            w_sum_mag;
   logic                      w_train;
   logic                      w_upd_ready;
   logic                      w_pred_ready;
   logic                      w_upd_fire;
   logic                      w_pred_fire;

   assign w_upd_ready  = (r_state == IDLE);
   assign w_pred_ready = (r_state != UPD_RD) && !((r_state == IDLE) && upd_valid);
   assign w_upd_fire   = upd_valid && w_upd_ready;
   assign w_pred_fire  = pred_valid && w_pred_ready;

   // One extra bit so the most negative sum maps to its true magnitude.
   always_comb begin
      if (upd_sum[SUM_W-1]) begin
         w_sum_mag = {1'b0, ~upd_sum} + (SUM_W+1)'(1);
      end else begin
         w_sum_mag = {1'b0, upd_sum};
      end
   end

   assign w_train = upd_mispred || (w_sum_mag <= (SUM_W+1)'(THRESH));

   pwt_train_unit #(
      .HIST_LEN (HIST_LEN),
      .WEIGHT_W (WEIGHT_W)
   ) u_train (
      .i_old_vec (r_mem[r_idx]),
      .i_hist    (r_hist),
      .i_taken   (r_taken),
      .o_new_vec (w_train_vec)
   );

   // Next-state logic of the training sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_upd_fire && w_train) begin
               w_state_nxt = UPD_RD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         UPD_RD:  w_state_nxt = UPD_WR;
         UPD_WR:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Training sequencer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Latch the accepted update and capture the trained vector.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx     <= '0;
         r_hist    <= '0;
         r_taken   <= 1'b0;
         r_new_vec <= '0;
      end else begin
         if (w_upd_fire) begin
            r_idx   <= upd_idx;
            r_hist  <= upd_hist;
            r_taken <= upd_taken;
         end
         if (r_state == UPD_RD) begin
            r_new_vec <= w_train_vec;
         end
      end
   end

   // Weight array; the only write port is the UPD_WR commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (r_state == UPD_WR) begin
         r_mem[r_idx] <= r_new_vec;
      end
   end

   // Per-way read mux, optionally forwarding the vector being committed.
   always_comb begin
      w_lookup = '0;
      for (int k = 0; k < NUM_WAYS; k++) begin
`ifdef PWT_WRITE_BYPASS_EN
         if ((r_state == UPD_WR) && (pred_idx[k*IDX_W +: IDX_W] == r_idx)) begin
            w_lookup[k*VEC_W +: VEC_W] = r_new_vec;
         end else begin
            w_lookup[k*VEC_W +: VEC_W] = r_mem[pred_idx[k*IDX_W +: IDX_W]];
         end
`else
         w_lookup[k*VEC_W +: VEC_W] = r_mem[pred_idx[k*IDX_W +: IDX_W]];
`endif
      end
   end

   // Registered lookup response and training pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_resp_valid   <= 1'b0;
         r_resp_weights <= '0;
         r_train_done   <= 1'b0;
      end else begin
         r_resp_valid <= w_pred_fire;
         if (w_pred_fire) begin
            r_resp_weights <= w_lookup;
         end
         r_train_done <= (r_state == UPD_RD);
      end
   end

   assign pred_ready   = w_pred_ready;
   assign upd_ready    = w_upd_ready;
   assign resp_valid   = r_resp_valid;
   assign resp_weights = r_resp_weights;
   assign train_done   = r_train_done;

endmodule

// File: tb/tb_perceptron_weight_table.sv
// Scoreboard bench for perceptron_weight_table: lookups push expected vectors,
// a monitor pops and compares on every resp_valid.
module tb_perceptron_weight_table;

   localparam int VW = 72;
   localparam int RW = 288;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           pred_valid = 1'b0;
   logic           pred_ready;
   logic [31:0]    pred_idx = '0;
   logic           resp_valid;
   logic [RW-1:0]  resp_weights;
   logic           upd_valid = 1'b0;
   logic           upd_ready;
   logic [7:0]     upd_idx = '0;
   logic [7:0]     upd_hist = '0;
   logic           upd_taken = 1'b0;
   logic           upd_mispred = 1'b0;
   logic [15:0]    upd_sum = '0;
   logic           train_done;

   int             n_checks = 0;
   int             n_errors = 0;
   int             td_cnt = 0;
   int             td0;
   logic [RW-1:0]  exp_q[$];
   logic [RW-1:0]  mon_exp;

   always #5 clk = ~clk;

   perceptron_weight_table dut (
      .clk          (clk),
      .rst          (rst),
      .pred_valid   (pred_valid),
      .pred_ready   (pred_ready),
      .pred_idx     (pred_idx),
      .resp_valid   (resp_valid),
      .resp_weights (resp_weights),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .upd_idx      (upd_idx),
      .upd_hist     (upd_hist),
      .upd_taken    (upd_taken),
      .upd_mispred  (upd_mispred),
      .upd_sum      (upd_sum),
      .train_done   (train_done)
   );

   function automatic logic [VW-1:0] vpat(input logic [7:0] p, input logic [7:0] n);
      logic [VW-1:0] v;
      for (int j = 0; j < 9; j++) v[j*8 +: 8] = (j == 0 || j == 6 || j == 8) ? p : n;
      return v;
   endfunction

   function automatic logic [RW-1:0] all4(input logic [VW-1:0] v);
      return {v, v, v, v};
   endfunction

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor: count training pulses and score every response.
   always @(negedge clk) begin
      if (rst === 1'b1 && train_done === 1'b1) td_cnt++;
      if (resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got %h required no response", resp_weights);
         end else begin
            mon_exp = exp_q.pop_front();
            check("resp_weights", resp_weights, mon_exp);
         end
      end
   end

   task automatic lookup(input logic [31:0] idxs, input logic [RW-1:0] exp);
      int n;
      @(posedge clk); #1;
      pred_valid = 1'b1;
      pred_idx   = idxs;
      n = 0;
      @(negedge clk);
      while (pred_ready !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (pred_ready === 1'b1) exp_q.push_back(exp);
      else begin
         n_checks++;
         n_errors++;
         $display("FAIL lookup_timeout: pred_ready %b required 1", pred_ready);
      end
      @(posedge clk); #1;
      pred_valid = 1'b0;
   endtask

   task automatic update(input logic [7:0] idx, input logic [7:0] hist, input logic taken,
                         input logic mis, input logic [15:0] sum);
      int n;
      @(posedge clk); #1;
      upd_valid   = 1'b1;
      upd_idx     = idx;
      upd_hist    = hist;
      upd_taken   = taken;
      upd_mispred = mis;
      upd_sum     = sum;
      n = 0;
      @(negedge clk);
      while (upd_ready !== 1'b1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (upd_ready !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL update_timeout: upd_ready %b required 1", upd_ready);
      end
      @(posedge clk); #1;
      upd_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      @(negedge clk);
      check("rst_pred_ready", pred_ready, 1'b1);
      check("rst_upd_ready", upd_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_weights", resp_weights, '0);
      check("rst_train_done", train_done, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      lookup({8'd255, 8'd5, 8'd5, 8'd0}, all4(vpat(8'h00, 8'h00)));

      // Mispredict training with train_done timing
      update(8'd5, 8'b1010_0000, 1'b1, 1'b1, 16'd0);
      @(negedge clk);
      check("rd_train_done", train_done, 1'b0);
      check("rd_pred_ready", pred_ready, 1'b0);
      check("rd_upd_ready", upd_ready, 1'b0);
      @(negedge clk);
      check("wr_train_done", train_done, 1'b1);
      check("wr_upd_ready", upd_ready, 1'b0);
      @(posedge clk); #1;
      lookup({4{8'd5}}, all4(vpat(8'h01, 8'hFF)));

      // Threshold boundaries
      td0 = td_cnt;
      update(8'd5, 8'hA0, 1'b1, 1'b0, 16'd30);
      settle();
      update(8'd5, 8'hA0, 1'b1, 1'b0, 16'h8000);
      settle();
      check("skip_no_train", td_cnt, td0);
      lookup({4{8'd5}}, all4(vpat(8'h01, 8'hFF)));
      update(8'd5, 8'hA0, 1'b1, 1'b0, 16'hFFE3);
      settle();
      lookup({4{8'd5}}, all4(vpat(8'h02, 8'hFE)));
      update(8'd5, 8'hA0, 1'b1, 1'b0, 16'd29);
      settle();
      check("thresh_train_cnt", td_cnt, td0 + 2);
      lookup({8'd5, 8'd0, 8'd5, 8'd0}, {vpat(8'h03, 8'hFD), vpat(8'h00, 8'h00),
                                        vpat(8'h03, 8'hFD), vpat(8'h00, 8'h00)});

      // Saturation
      for (int i = 0; i < 130; i++) begin
         update(8'd7, 8'hFF, 1'b1, 1'b1, 16'd0);
         settle();
      end
      lookup({4{8'd7}}, all4(vpat(8'h7F, 8'h7F)));
      for (int i = 0; i < 260; i++) begin
         update(8'd7, 8'hFF, 1'b0, 1'b1, 16'd0);
         settle();
      end
      lookup({8'd7, 8'd5, 8'd7, 8'd7}, {vpat(8'h80, 8'h80), vpat(8'h03, 8'hFD),
                                        vpat(8'h80, 8'h80), vpat(8'h80, 8'h80)});

      // Contention: update wins in IDLE, lookup stalls through UPD_RD
      @(posedge clk); #1;
      pred_valid  = 1'b1;
      pred_idx    = {4{8'd5}};
      upd_valid   = 1'b1;
      upd_idx     = 8'd5;
      upd_hist    = 8'hA0;
      upd_taken   = 1'b1;
      upd_mispred = 1'b1;
      upd_sum     = 16'd0;
      @(negedge clk);
      check("cont_pred_ready_idle", pred_ready, 1'b0);
      check("cont_upd_ready_idle", upd_ready, 1'b1);
      @(posedge clk); #1;
      upd_valid = 1'b0;
      @(negedge clk);
      check("cont_pred_ready_rd", pred_ready, 1'b0);
      @(negedge clk);
      check("cont_pred_ready_wr", pred_ready, 1'b1);
      check("cont_train_done_wr", train_done, 1'b1);
`ifdef PWT_WRITE_BYPASS_EN
      exp_q.push_back(all4(vpat(8'h04, 8'hFC)));
`else
      exp_q.push_back(all4(vpat(8'h03, 8'hFD)));
`endif
      @(posedge clk); #1;
      pred_valid = 1'b0;
      settle();
      lookup({4{8'd5}}, all4(vpat(8'h04, 8'hFC)));

      // Reset while the trainer is in UPD_RD
      td0 = td_cnt;
      update(8'd9, 8'hFF, 1'b1, 1'b1, 16'd0);
      #2;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_train_done", train_done, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_pred_ready", pred_ready, 1'b1);
      check("midrst_upd_ready", upd_ready, 1'b1);
      check("midrst_no_train", td_cnt, td0);
      lookup({8'd0, 8'd7, 8'd5, 8'd9}, all4(vpat(8'h00, 8'h00)));

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
